// File: rtl/norm_check_defines_pkg.sv
// Shared types and constants for the norm-check memory reader/writer pair.
// Modes, write FSM states and per-mode beat totals.
package norm_check_defines_pkg;

  typedef enum logic [1:0] {
    z_bound   = 2'd0,
    r0_bound  = 2'd1,
    ct0_bound = 2'd2
  } chk_norm_mode_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_MEM,
    WR_FLUSH,
    WR_DONE
  } chk_write_state_e;

  localparam int Z_NUM_BEATS = 448;
  localparam int R_NUM_BEATS = 512;

  // Counter value of the final beat for a given mode.
  function automatic logic [9:0] last_beat_idx(
    input logic [1:0] mode
  );
    if (mode == z_bound)
      return 10'(Z_NUM_BEATS - 1);
    return 10'(R_NUM_BEATS - 1);
  endfunction

endpackage

// File: rtl/norm_check_mem_writer.sv
// Streams packed coefficient beats into consecutive polynomial memory words
// for the norm-check reader; length set by the norm-check mode.
module norm_check_mem_writer
  import norm_check_defines_pkg::*;
#(
  parameter int REG_SIZE       = 24,
  parameter int MEM_ADDR_WIDTH = 15,
  parameter int COEFF_PER_BEAT = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               zeroize,
  input  logic                               en_i,
  input  logic [1:0]                         mode_i,
  input  logic [MEM_ADDR_WIDTH-1:0]          base_addr_i,
  input  logic                               data_valid_i,
  input  logic [COEFF_PER_BEAT*REG_SIZE-1:0] data_i,
  output logic                               data_ready_o,
  output logic                               mem_wr_en_o,
  output logic [MEM_ADDR_WIDTH-1:0]          mem_wr_addr_o,
  output logic [COEFF_PER_BEAT*REG_SIZE-1:0] mem_wr_data_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o
);

  chk_write_state_e            state;
  logic [9:0]                  cnt;
  logic [1:0]                  mode_q;
  logic [MEM_ADDR_WIDTH-1:0]   base_q;
  logic                        accept;
  logic                        last_beat;

  assign data_ready_o = (state == WR_MEM);
  assign busy_o       = (state != WR_IDLE);
  assign accept       = data_ready_o & data_valid_i;
  assign last_beat    = (cnt == last_beat_idx(mode_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WR_IDLE;
      cnt           <= '0;
      mode_q        <= '0;
      base_q        <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else if (zeroize) begin
      state         <= WR_IDLE;
      cnt           <= '0;
      mode_q        <= '0;
      base_q        <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      mem_wr_en_o <= 1'b0;
      done_o      <= 1'b0;
      unique case (state)
        WR_IDLE: begin
          if (en_i) begin
            mode_q <= mode_i;
            base_q <= base_addr_i;
            cnt    <= '0;
            err_o  <= 1'b0;
            // Reserved mode skips straight to completion, flagged.
            if (mode_i == 2'h3) begin
              state  <= WR_DONE;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else begin
              state <= WR_MEM;
            end
          end
        end
        WR_MEM: begin
          if (accept) begin
            mem_wr_en_o   <= 1'b1;
            mem_wr_addr_o <= base_q + MEM_ADDR_WIDTH'(cnt);
            mem_wr_data_o <= data_i;
            cnt           <= cnt + 10'd1;
            if (last_beat)
              state <= WR_FLUSH;
          end
        end
        WR_FLUSH: begin
          state  <= WR_DONE;
          done_o <= 1'b1;
        end
        WR_DONE: state <= WR_IDLE;
        default: state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_check_mem_writer.sv
// Randomized directed bench for norm_check_mem_writer against a
// queue-based model of expected memory writes.
module tb_norm_check_mem_writer;

  localparam int AW = 15;
  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          zeroize = 1'b0;
  logic          en_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [AW-1:0] base_addr_i = '0;
  logic          data_valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          data_ready_o;
  logic          mem_wr_en_o;
  logic [AW-1:0] mem_wr_addr_o;
  logic [DW-1:0] mem_wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  norm_check_mem_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .zeroize      (zeroize),
    .en_i         (en_i),
    .mode_i       (mode_i),
    .base_addr_i  (base_addr_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .data_ready_o (data_ready_o),
    .mem_wr_en_o  (mem_wr_en_o),
    .mem_wr_addr_o(mem_wr_addr_o),
    .mem_wr_data_o(mem_wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input logic exp_wr);
    chk("wr_en", 128'(mem_wr_en_o), 128'(exp_wr));
    if (mem_wr_en_o) begin
      chk("wr_queue", 128'(exp_addr.size() != 0), 128'(1'b1));
      if (exp_addr.size() != 0) begin
        chk("wr_addr", 128'(mem_wr_addr_o), 128'(exp_addr.pop_front()));
        chk("wr_data", 128'(mem_wr_data_o), 128'(exp_data.pop_front()));
      end
    end
  endtask

  // Caller is at a negedge with the DUT idle.
  task automatic run(input logic [1:0] mode, input logic [AW-1:0] base,
                     input int gap_pct, input int zero_at,
                     input int intr_at, input bit seq);
    int            n;
    int            sent;
    logic          acc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    n    = (mode == 2'd0) ? 7 * 64 : 8 * 64;
    sent = 0;
    acc  = 1'b0;
    en_i = 1'b1;
    mode_i = mode;
    base_addr_i = base;
    data_valid_i = 1'b0;
    @(negedge clk);
    en_i = 1'b0;
    chk("start_busy", 128'(busy_o), 128'(1'b1));
    chk("start_err", 128'(err_o), 128'(1'b0));
    while (sent < n) begin
      check_write(acc);
      chk("run_ready", 128'(data_ready_o), 128'(1'b1));
      chk("run_done", 128'(done_o), 128'(1'b0));
      if (zero_at >= 0 && sent == zero_at) begin
        data_valid_i = 1'b0;
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk("zero_wr", 128'(mem_wr_en_o), 128'(1'b0));
        chk("zero_busy", 128'(busy_o), 128'(1'b0));
        chk("zero_ready", 128'(data_ready_o), 128'(1'b0));
        chk("zero_done", 128'(done_o), 128'(1'b0));
        chk("zero_q", 128'(exp_addr.size()), 128'(0));
        return;
      end
      if (sent == intr_at) begin
        en_i = 1'b1;
        base_addr_i = base ^ 15'h2AAA;
        mode_i = 2'h3;
      end else begin
        en_i = 1'b0;
      end
      data_valid_i = ($urandom_range(99) >= gap_pct);
      d = seq ? DW'(sent) : {$urandom, $urandom, $urandom};
      data_i = d;
      acc = data_valid_i;
      if (acc) begin
        a = base + AW'(sent);
        exp_addr.push_back(a);
        exp_data.push_back(d);
        sent++;
      end
      @(negedge clk);
    end
    en_i = 1'b0;
    data_valid_i = 1'b1;
    check_write(1'b1);
    chk("flush_ready", 128'(data_ready_o), 128'(1'b0));
    chk("flush_busy", 128'(busy_o), 128'(1'b1));
    chk("flush_done", 128'(done_o), 128'(1'b0));
    @(negedge clk);
    check_write(1'b0);
    chk("done_pulse", 128'(done_o), 128'(1'b1));
    chk("done_busy", 128'(busy_o), 128'(1'b1));
    chk("done_err", 128'(err_o), 128'(1'b0));
    @(negedge clk);
    check_write(1'b0);
    chk("end_done", 128'(done_o), 128'(1'b0));
    chk("end_busy", 128'(busy_o), 128'(1'b0));
    chk("end_q", 128'(exp_addr.size()), 128'(0));
    data_valid_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(data_ready_o), 128'(1'b0));
    chk("rst_wr", 128'(mem_wr_en_o), 128'(1'b0));
    chk("rst_addr", 128'(mem_wr_addr_o), 128'(0));
    chk("rst_data", 128'(mem_wr_data_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(1'b0));
    chk("rst_done", 128'(done_o), 128'(1'b0));
    chk("rst_err", 128'(err_o), 128'(1'b0));
    reset_n = 1'b1;
    @(negedge clk);

    run(2'd0, 15'h0100, 0, -1, -1, 1'b1);
    run(2'd2, 15'h1234, 45, -1, -1, 1'b0);
    run(2'd1, 15'h7F00, 10, -1, -1, 1'b0);

    en_i = 1'b1;
    mode_i = 2'h3;
    base_addr_i = 15'h0300;
    data_valid_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
    chk("rsv_done", 128'(done_o), 128'(1'b1));
    chk("rsv_err", 128'(err_o), 128'(1'b1));
    chk("rsv_wr", 128'(mem_wr_en_o), 128'(1'b0));
    chk("rsv_ready", 128'(data_ready_o), 128'(1'b0));
    @(negedge clk);
    chk("rsv_done2", 128'(done_o), 128'(1'b0));
    chk("rsv_err2", 128'(err_o), 128'(1'b1));
    chk("rsv_busy2", 128'(busy_o), 128'(1'b0));
    chk("rsv_wr2", 128'(mem_wr_en_o), 128'(1'b0));
    data_valid_i = 1'b0;
    @(negedge clk);

    run(2'd0, 15'h0040, 5, -1, -1, 1'b0);
    run(2'd1, 15'h0500, 20, 100, -1, 1'b0);
    run(2'd0, 15'h0000, 15, -1, -1, 1'b0);
    run(2'd2, 15'h0200, 30, -1, 50, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/norm_check_mem_writer.md
# norm_check_mem_writer

Producer-side partner of the norm-check memory reader. Accepts a stream of packed 4-coefficient beats from the upstream datapath (decompose, sampler or NTT output) and writes them to consecutive addresses in the shared polynomial memory. The norm-check reader later scans that region. The write length follows the norm-check mode: 7 polynomials for the z check, 8 for the r0 and ct0 checks. Completion is reported with a one-cycle done pulse.

## Interface
Parameters:
- REG_SIZE, 24, bits per coefficient
- MEM_ADDR_WIDTH, 15, memory address width
- COEFF_PER_BEAT, 4, coefficients per beat and per memory word

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear; same effect as reset
- en_i  in  1  start pulse; sampled only in WR_IDLE
- mode_i  in  2  chk_norm_mode_t; latched on start
- base_addr_i  in  MEM_ADDR_WIDTH  first write address; latched on start
- data_valid_i  in  1  upstream beat valid
- data_i  in  COEFF_PER_BEAT*REG_SIZE  packed beat; coefficient 0 in the LSBs
- data_ready_o  out  1  beat accepted when valid and ready are both high
- mem_wr_en_o  out  1  memory write strobe
- mem_wr_addr_o  out  MEM_ADDR_WIDTH  write address
- mem_wr_data_o  out  COEFF_PER_BEAT*REG_SIZE  write data
- busy_o  out  1  high in every state except WR_IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  reserved mode flag; stays high until the next start

## Operation
- States are chk_write_state_e: WR_IDLE, WR_MEM, WR_FLUSH, WR_DONE.
- **WR_IDLE, en_i=1:**
  - latch mode and base address
  - clear the beat counter and err_o
  - go to WR_MEM for a valid mode (0, 1, 2)
  - go to WR_DONE with err_o=1 for mode 2'h3; no writes occur
- **Beat totals:** z_bound gives 7×64 = 448 beats. r0_bound and ct0_bound give 8×64 = 512 beats.
- **WR_MEM:**
  - data_ready_o=1, driven combinationally from state
  - each accepted beat is registered and written the next cycle at base + counter
  - the address wraps modulo 2^MEM_ADDR_WIDTH
  - the counter is 10 bits and increments on each accept
- **End of stream:** on acceptance of the final beat, go to WR_FLUSH. The last write goes out during WR_FLUSH and data_ready_o=0.
- **WR_FLUSH:** go to WR_DONE.
- **WR_DONE:** done_o=1 for exactly one cycle, then go to WR_IDLE.
- **Ignored inputs:**
  - en_i outside WR_IDLE is ignored, so a restart needs a fresh pulse in WR_IDLE
  - data_valid_i outside WR_MEM is ignored
  - data_i is not checked or modified
- **Zeroize:** takes priority over every other event in any state. It clears the state, counter, latched registers, output registers and err_o, and no write is issued in the following cycle.
- **Reset:** every output is 0; state is WR_IDLE.

## Timing
- Accept at cycle t gives mem_wr_en_o=1 at t+1, with the address and data registered.
- Throughput is one beat per cycle with no bubbles. A valid-low cycle produces a write-low cycle.
- Final accept at t gives: state WR_FLUSH at t+1 (last write), done_o at t+2, busy_o=0 at t+3.
- Start pulse at t gives: state WR_MEM and data_ready_o=1 at t+1.
- Reserved mode: done_o and err_o are high at t+1; busy_o=0 at t+2.
- Back-to-back: en_i asserted in the first WR_IDLE cycle starts the next run with no extra latency.
- mem_wr_en_o is never high in WR_IDLE or WR_DONE.

## Structure
- Add to norm_check_defines_pkg:
  - chk_write_state_e enum
  - beat-count constants: Z_NUM_BEATS=448, R_NUM_BEATS=512
  - the existing z_bound, r0_bound and ct0_bound are reused
- No sub-module is needed: one FSM, one counter and one output register stage in a single file.

## Test plan
- **z mode:** mode=0, base=0x100, 448 continuous beats with data=beat index → 448 writes at 0x100..0x2BF with matching data, done_o at last accept +2, err_o=0.
- **ct0 mode with gaps:** mode=2, 512 beats, valid toggling randomly → exactly 512 writes, contiguous addresses, order preserved, no write in valid-low cycles.
- **Address wrap:** base=0x7F00, mode=1 → addresses run 0x7F00..0x7FFF then 0x0000..0x00FF.
- **Reserved mode:** mode=3 → no mem_wr_en_o, done_o and err_o high one cycle after en_i, err_o cleared by the next valid start.
- **Zeroize mid-run:** zeroize after beat 100 → next cycle mem_wr_en_o=0 and busy_o=0; a following start at base=0 rewrites from address 0 with counter 0.
- **Start while busy:** en_i with a new base during WR_MEM → ignored; addresses continue from the original base.
